// File: rtl/lut_digit_sequencer_if.sv
// Operand/result handshake bundle for lut_digit_sequencer.
// valid/ready: a transfer happens on a rising clk edge where both are high; a
// producer holds valid and its payload stable until that edge and does not
// wait for ready before asserting valid.
interface lut_digit_sequencer_if #(
  parameter int DIGITS = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [2*DIGITS-1:0]   in_a;
  logic [2*DIGITS-1:0]   in_b;
  logic                  out_valid;
  logic                  out_ready;
  logic [2*DIGITS-1:0]   out_data;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/lut_digit_sequencer.sv
// Walks two multi-digit operands through an external 2-bit LUT ROM one digit
// pair per cycle (LSB first) and assembles the per-digit results into one word.
module lut_digit_sequencer #(
  parameter int DIGITS = 4,
  parameter int CNT_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  lut_digit_sequencer_if.slave  io,
  output logic [3:0]            lut_addr,
  input  logic [1:0]            lut_data,
  output logic                  busy,
  output logic [1:0]            dbg_state
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIGITS - 1);

  logic [1:0]          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2*DIGITS-1:0] a_q, a_d;
  logic [2*DIGITS-1:0] b_q, b_d;
  logic [2*DIGITS-1:0] out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic [1:0]          a_dig, b_dig;

  // Digit pair selected by the counter; only meaningful while in RUN.
  always_comb begin
    a_dig = 2'b00;
    b_dig = 2'b00;
    for (int i = 0; i < DIGITS; i++) begin
      if (cnt_q == CNT_W'(i)) begin
        a_dig = a_q[2*i +: 2];
        b_dig = b_q[2*i +: 2];
      end
    end
  end

  always_comb begin
    lut_addr = 4'b0000;
    if (state_q == RUN) lut_addr = {a_dig, b_dig};
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (io.in_valid) begin
          a_d     = io.in_a;
          b_d     = io.in_b;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < DIGITS; i++) begin
          if (cnt_q == CNT_W'(i)) out_data_d[2*i +: 2] = lut_data;
        end
        // Final digit: stop here instead of letting the counter wrap.
        if (cnt_q == LAST) begin
          cnt_d       = '0;
          state_d     = DONE;
          out_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (io.out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign io.in_ready  = (state_q == IDLE);
  assign io.out_valid = out_valid_q;
  assign io.out_data  = out_data_q;
  assign busy         = (state_q == RUN) || (state_q == DONE);
  assign dbg_state    = state_q;

endmodule
